// File: rtl/counter_pkg.sv
// Shared types for the countdown timer block.
package counter_pkg;

  // Timer control states: IDLE holds the count, RUN decrements, PAUSED freezes.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: emits a tick once every PRESCALE enabled
// cycles. The phase is frozen while en is low and forced to zero by clr.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_direct
      // Every enabled cycle is a tick; no state is needed.
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst_n, clr};
      assign tick     = en;
    end else begin : g_count
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] phase_r;

      assign tick = en && (phase_r == PW'(PRESCALE - 1));

      // Phase counter: cleared on clr, advances only when enabled, wraps on tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_r <= '0;
        end else if (clr) begin
          phase_r <= '0;
        end else if (en) begin
          phase_r <= tick ? '0 : (phase_r + PW'(1));
        end else begin
          phase_r <= phase_r;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, start/pause control,
// one-cycle terminal-count pulse and optional auto-reload.
import counter_pkg::*;

module countdown_timer #(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_r, state_next_s;
  logic [WIDTH-1:0] count_r, count_next_s;
  logic [WIDTH-1:0] reload_r, reload_next_s;
  logic             done_r, done_next_s;
  logic             busy_r;
  logic             clr_s, en_s, tick_s;

  // Prescaler restarts on a load or a fresh start; it only advances while
  // running and not being paused or loaded this edge.
  assign clr_s = ld || ((state_r == IDLE) && start);
  assign en_s  = (state_r == RUN) && !ld && !pause;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (en_s),
    .tick  (tick_s)
  );

  // Next-state and datapath decisions; priority is ld > pause > start > tick.
  always_comb begin
    state_next_s  = state_r;
    count_next_s  = count_r;
    reload_next_s = reload_r;
    done_next_s   = 1'b0;
    if (ld) begin
      count_next_s  = v;
      reload_next_s = v;
      state_next_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (count_r != '0) begin
              state_next_s = RUN;
            end else begin
              done_next_s = 1'b1;
            end
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            state_next_s = PAUSED;
          end else if (tick_s) begin
            if (count_r == WIDTH'(1)) begin
              done_next_s = 1'b1;
              if ((AUTO_RELOAD != 0) && (reload_r != '0)) begin
                count_next_s = reload_r;
              end else begin
                count_next_s = '0;
                state_next_s = IDLE;
              end
            end else begin
              count_next_s = count_r - WIDTH'(1);
            end
          end else begin
            state_next_s = RUN;
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_next_s = RUN;
          end else begin
            state_next_s = PAUSED;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State, count, reload and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= '0;
      reload_r <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      count_r  <= count_next_s;
      reload_r <= reload_next_s;
      done_r   <= done_next_s;
      busy_r   <= (state_next_s != IDLE);
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule
